// File: rtl/core2wb.sv
// core2wb: bridges an Ibex core memory port (req/gnt, rvalid) to a Wishbone B4
// pipelined master. Outstanding transfers are counted up to MAX_OUTSTANDING and
// each ack/err is returned to the core as a registered one-cycle response.
// Build option: define CORE2WB_REG_REQ_EN to insert a one-entry request register
// so that wb_stb/wb_we/wb_adr/wb_sel/wb_dat_o come only from flops.
module core2wb #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    core_req,
    output logic                    core_gnt,
    input  logic                    core_we,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    output logic                    core_rvalid,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_err,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_stall,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH:0] MAX_OCC = (CNT_WIDTH + 1)'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 cnt_nz;
    logic                 issue;
    logic                 retire;

    // A response only retires a transfer if one is actually outstanding.
    assign cnt_nz = (cnt != '0);
    assign retire = (wb_ack | wb_err) & cnt_nz;

`ifdef CORE2WB_REG_REQ_EN
    logic                    buf_valid;
    logic                    buf_we;
    logic [ADDR_WIDTH-1:0]   buf_adr;
    logic [DATA_WIDTH/8-1:0] buf_sel;
    logic [DATA_WIDTH-1:0]   buf_dat;
    logic [CNT_WIDTH:0]      occ;
    logic                    room_r;

    // Occupancy includes the buffered request; a retire this cycle frees a slot,
    // which keeps a full pipeline granting one request per cycle.
    assign occ      = {1'b0, cnt} + (CNT_WIDTH + 1)'(buf_valid) - (CNT_WIDTH + 1)'(retire);
    assign room_r   = (occ < MAX_OCC);
    assign core_gnt = rst_ni & core_req & room_r & (~buf_valid | ~wb_stall);
    assign issue    = buf_valid & ~wb_stall;

    assign wb_stb   = buf_valid;
    assign wb_we    = buf_we;
    assign wb_adr   = buf_adr;
    assign wb_sel   = buf_sel;
    assign wb_dat_o = buf_dat;

    // One-entry request buffer: load on grant, drain when Wishbone accepts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_valid <= 1'b0;
            buf_we    <= 1'b0;
            buf_adr   <= '0;
            buf_sel   <= '0;
            buf_dat   <= '0;
        end else if (core_gnt) begin
            buf_valid <= 1'b1;
            buf_we    <= core_we;
            buf_adr   <= core_addr;
            buf_sel   <= core_be;
            buf_dat   <= core_wdata;
        end else if (buf_valid && !wb_stall) begin
            buf_valid <= 1'b0;
        end
    end
`else
    logic room;

    // Pass-through request path: the strobe is the qualified core request.
    assign room     = ({1'b0, cnt} < MAX_OCC);
    assign wb_stb   = rst_ni & core_req & room;
    assign core_gnt = wb_stb & ~wb_stall;
    assign issue    = core_gnt;

    assign wb_we    = core_we;
    assign wb_adr   = core_addr;
    assign wb_sel   = core_be;
    assign wb_dat_o = core_wdata;
`endif

    // Cycle stays asserted while anything is in flight.
    assign wb_cyc = wb_stb | cnt_nz;

    // Outstanding counter update; simultaneous issue and retire cancel.
    always_comb begin
        cnt_next = cnt;
        if (issue && !retire) begin
            cnt_next = cnt + CNT_WIDTH'(1);
        end else if (retire && !issue) begin
            cnt_next = cnt - CNT_WIDTH'(1);
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Registered response; error wins over ack and returns zero data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            core_rdata  <= '0;
        end else begin
            core_rvalid <= retire;
            core_err    <= wb_err & retire;
            core_rdata  <= (wb_ack & ~wb_err & retire) ? wb_dat_i : '0;
        end
    end

endmodule

// File: tb/tb_core2wb.sv
// tb_core2wb: directed and randomized bench for core2wb with a queue-based
// reference model of granted requests, Wishbone-accepted transfers and responses.
module tb_core2wb;

    localparam int MAX = 2;
`ifdef CORE2WB_REG_REQ_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_gnt, core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_rvalid, core_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_stall, wb_ack, wb_err;

    int total = 0;
    int bad   = 0;

    req_t core_q[$];
    req_t pend_q[$];
    logic        exp_rv = 1'b0, exp_er = 1'b0;
    logic [31:0] exp_rd = '0;
    bit          armed = 1'b0, prev_rst_low = 1'b0;
    int          n_acc = 0, n_resp = 0;

    core2wb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
        .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_stall(wb_stall), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_be = '0; core_addr = '0; core_wdata = '0;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    endtask

    // Reference model: sampled mid-cycle, describes what the next edge does.
    always @(negedge clk) begin
        req_t r;
        if (armed) begin
            chk("rsp_valid", 64'(core_rvalid), 64'(exp_rv));
            chk("rsp_err", 64'(core_err), 64'(exp_er));
            chk("rsp_data", 64'(core_rdata), 64'(exp_rd));
            if (!rst_n) begin
                chk("rst_gnt", 64'(core_gnt), 64'(0));
                if (prev_rst_low) begin
                    chk("rst_cyc", 64'(wb_cyc), 64'(0));
                    chk("rst_stb", 64'(wb_stb), 64'(0));
                end
            end else begin
                chk("mon_cyc", 64'(wb_cyc), 64'(wb_stb | (pend_q.size() != 0)));
`ifndef CORE2WB_REG_REQ_EN
                chk("mon_stb", 64'(wb_stb), 64'(core_req & (pend_q.size() < MAX)));
                chk("mon_gnt", 64'(core_gnt), 64'(core_req & ~wb_stall & (pend_q.size() < MAX)));
`endif
            end
        end
        if (!rst_n) begin
            core_q.delete();
            pend_q.delete();
            exp_rv = 1'b0; exp_er = 1'b0; exp_rd = '0;
            n_acc = 0; n_resp = 0;
            armed = 1'b1;
        end else begin
            if (core_gnt)
                core_q.push_back('{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata});
            if ((wb_ack || wb_err) && pend_q.size() != 0) begin
                void'(pend_q.pop_front());
                exp_rv = 1'b1;
                exp_er = wb_err;
                exp_rd = wb_err ? 32'h0 : wb_dat_i;
                n_resp++;
            end else begin
                exp_rv = 1'b0; exp_er = 1'b0; exp_rd = '0;
            end
            if (wb_stb && !wb_stall) begin
                chk("mon_orphan", 64'(core_q.size() != 0), 64'(1));
                if (core_q.size() != 0) begin
                    r = core_q.pop_front();
                    chk("mon_adr", 64'(wb_adr), 64'(r.addr));
                    chk("mon_we", 64'(wb_we), 64'(r.we));
                    chk("mon_sel", 64'(wb_sel), 64'(r.be));
                    chk("mon_dat", 64'(wb_dat_o), 64'(r.wdata));
                    pend_q.push_back(r);
                    n_acc++;
                    chk("mon_limit", 64'(pend_q.size() <= MAX), 64'(1));
                end
            end
        end
        prev_rst_low = !rst_n;
    end

    initial begin
        int g, rv;
        logic [15:0] gbits, rbits;
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        // Reset state, with a request pending to show grant is held off
        core_req = 1'b1;
        #1;
        chk("rst_gnt_forced", 64'(core_gnt), 64'(0));
        chk("rst_stb_forced", 64'(wb_stb), 64'(0));
        chk("rst_cyc", 64'(wb_cyc), 64'(0));
        chk("rst_rvalid", 64'(core_rvalid), 64'(0));
        chk("rst_rdata", 64'(core_rdata), 64'(0));
        core_req = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1: single read
        core_req = 1'b1; core_addr = 32'h0000_1000; core_be = 4'hF;
        #1 chk("t1_gnt", 64'(core_gnt), 64'(1));
        tick();
        idle();
        repeat (XL) begin
            chk("t1_stb_late", 64'(wb_stb), 64'(1));
            tick();
        end
        wb_ack = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        #1 chk("t1_cyc_hold", 64'(wb_cyc), 64'(1));
        tick();
        idle();
        #1;
        chk("t1_rvalid", 64'(core_rvalid), 64'(1));
        chk("t1_rdata", 64'(core_rdata), 64'hDEAD_BEEF);
        chk("t1_err", 64'(core_err), 64'(0));
        chk("t1_cyc_drop", 64'(wb_cyc), 64'(0));
        tick();
        chk("t1_pulse", 64'(core_rvalid), 64'(0));

        // 2: write held off by stall
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h1234_5678;
        core_be = 4'h3; wb_stall = 1'b1;
`ifdef CORE2WB_REG_REQ_EN
        #1 chk("t2_gnt_buf", 64'(core_gnt), 64'(1));
        tick();
        core_req = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
`ifndef CORE2WB_REG_REQ_EN
            chk("t2_gnt_stall", 64'(core_gnt), 64'(0));
`endif
            chk("t2_stb", 64'(wb_stb), 64'(1));
            chk("t2_sel", 64'(wb_sel), 64'h3);
            chk("t2_dat", 64'(wb_dat_o), 64'h1234_5678);
            tick();
        end
        wb_stall = 1'b0;
        #1;
`ifndef CORE2WB_REG_REQ_EN
        chk("t2_gnt", 64'(core_gnt), 64'(1));
`endif
        chk("t2_sel_final", 64'(wb_sel), 64'h3);
        tick();
        idle();
        wb_ack = 1'b1; wb_dat_i = 32'hAA;
        tick();
        idle();
        chk("t2_rvalid", 64'(core_rvalid), 64'(1));
        chk("t2_rdata", 64'(core_rdata), 64'hAA);
        tick();

        // 3: outstanding limit with ack withheld
        core_req = 1'b1; core_be = 4'hF; g = 0;
        for (int i = 0; i < 5; i++) begin
            core_addr = 32'h100 + 32'(i * 4);
            #1 if (core_gnt) g++;
            tick();
        end
        chk("t3_grants_limit", 64'(g), 64'(2));
        g = 0; rv = 0; wb_ack = 1'b1; wb_dat_i = 32'h301;
        for (int j = 0; j < 4; j++) begin
            #1 if (core_gnt) g++;
            tick();
            wb_ack = 1'b0;
            if (core_rvalid) rv++;
        end
        chk("t3_one_more_gnt", 64'(g), 64'(1));
        chk("t3_one_rvalid", 64'(rv), 64'(1));
        idle();
        repeat (2) tick();
        wb_ack = 1'b1; wb_dat_i = 32'h302;
        tick();
        wb_dat_i = 32'h303;
        chk("t3_rv_a", 64'(core_rvalid), 64'(1));
        chk("t3_rd_a", 64'(core_rdata), 64'h302);
        tick();
        idle();
        chk("t3_rv_b", 64'(core_rvalid), 64'(1));
        chk("t3_rd_b", 64'(core_rdata), 64'h303);
        tick();
        chk("t3_rv_end", 64'(core_rvalid), 64'(0));
        chk("t3_cyc_end", 64'(wb_cyc), 64'(0));

        // 4: error response, then a clean read, then ack+err together
        for (int k = 0; k < 3; k++) begin
            core_req = 1'b1; core_be = 4'hF; core_addr = 32'h40 + 32'(k * 4);
            #1 chk("t4_gnt", 64'(core_gnt), 64'(1));
            tick();
            idle();
            repeat (XL) tick();
            wb_ack = (k != 0); wb_err = (k != 1); wb_dat_i = 32'h55 + 32'(k);
            tick();
            idle();
            chk("t4_rvalid", 64'(core_rvalid), 64'(1));
            chk("t4_err", 64'(core_err), 64'(k != 1));
            chk("t4_rdata", 64'(core_rdata), (k == 1) ? 64'h56 : 64'h0);
            tick();
        end

        // 5: spurious ack, then reset with two transfers in flight
        wb_ack = 1'b1; wb_dat_i = 32'h99;
        tick();
        idle();
        chk("t5_spurious", 64'(core_rvalid), 64'(0));
        core_req = 1'b1; core_be = 4'hF; core_addr = 32'h80;
        tick();
        core_addr = 32'h84;
        tick();
        idle();
        repeat (2) tick();
        chk("t5_cyc_busy", 64'(wb_cyc), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("t5_rst_cyc", 64'(wb_cyc), 64'(0));
        chk("t5_rst_stb", 64'(wb_stb), 64'(0));
        rst_n = 1'b1;
        tick();
        wb_ack = 1'b1; wb_dat_i = 32'hBAD;
        tick();
        idle();
        chk("t5_late_ack", 64'(core_rvalid), 64'(0));
        tick();

        // 6: eight back-to-back reads with ack every cycle
        gbits = '0; rbits = '0;
        for (int c = 0; c < 14; c++) begin
            core_req = (c < 8); core_be = 4'hF; core_addr = 32'h200 + 32'(c * 4);
            wb_ack = (pend_q.size() != 0); wb_dat_i = 32'h6000 + 32'(c);
            #1 gbits[c] = core_gnt;
            if (c >= 1 + XL && c < 8) chk("t6_outstanding", 64'(pend_q.size()), 64'(1));
            tick();
            rbits[c] = core_rvalid;
            if (core_rvalid) chk("t6_rdata", 64'(core_rdata), 64'(32'h6000 + 32'(c)));
        end
        idle();
        chk("t6_gnt_pattern", 64'(gbits), 64'h00FF);
        chk("t6_rv_pattern", 64'(rbits), 64'(16'h00FF << (1 + XL)));
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            core_req = ($urandom % 10) < 6;
            core_we = 1'($urandom % 2);
            core_be = 4'($urandom);
            core_addr = $urandom;
            core_wdata = $urandom;
            wb_stall = ($urandom % 10) < 3;
            wb_dat_i = $urandom;
            if (pend_q.size() != 0 && ($urandom % 10) < 6) begin
                wb_err = ($urandom % 8) == 0;
                wb_ack = wb_err ? 1'($urandom % 2) : 1'b1;
            end else begin
                wb_err = 1'b0;
                wb_ack = (pend_q.size() == 0) && (($urandom % 20) == 0);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 30; i++) begin
            wb_ack = (pend_q.size() != 0); wb_dat_i = $urandom;
            tick();
        end
        idle();
        tick();
        chk("drain_pending", 64'(pend_q.size()), 64'(0));
        chk("drain_core_q", 64'(core_q.size()), 64'(0));
        chk("drain_count", 64'(n_resp), 64'(n_acc));
        chk("drain_cyc", 64'(wb_cyc), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core2wb.md
Name: core2wb

Overview:
- Bridges the Ibex core memory interface, as seen from the core's instruction or data port, to a Wishbone B4 pipelined master.
- The core side is a slave. It accepts req/gnt requests and returns rvalid/rdata/err responses.
- The Wishbone side issues cyc/stb cycles, honours stall, and tracks outstanding transfers until ack/err.
- One instance sits between each ibex port and the system Wishbone interconnect.

Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered Wishbone transfers (1..15)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- core_req  in  1  core request
- core_gnt  out  1  request accepted this cycle
- core_we  in  1  write enable
- core_be  in  DATA_WIDTH/8  byte enables
- core_addr  in  ADDR_WIDTH  byte address
- core_wdata  in  DATA_WIDTH  write data
- core_rvalid  out  1  response valid
- core_rdata  out  DATA_WIDTH  read data
- core_err  out  1  response is an error
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write
- wb_adr  out  ADDR_WIDTH  Wishbone address
- wb_sel  out  DATA_WIDTH/8  Wishbone byte select
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_stall  in  1  slave not accepting
- wb_ack  in  1  transfer acknowledged
- wb_err  in  1  transfer error

Behaviour:

Reset:
- Single clock clk_i. Reset is synchronous and active-low on rst_ni.
- While rst_ni=0 at a clock edge: outstanding count cleared to 0; wb_cyc=0, wb_stb=0, core_rvalid=0, core_err=0, core_rdata=0.
- core_gnt is forced 0 while rst_ni=0.

Request path (default build):
- cnt counts accepted, unanswered transfers. It is 0..MAX_OUTSTANDING wide, $clog2(MAX_OUTSTANDING+1) bits.
- room = (cnt < MAX_OUTSTANDING).
- wb_stb = core_req & room.
- wb_we, wb_adr, wb_sel, wb_dat_o pass through combinationally from core_we, core_addr, core_be, core_wdata.
- core_gnt = core_req & room & ~wb_stall. A transfer is issued exactly when core_gnt=1.
- wb_cyc = wb_stb | (cnt != 0). cyc never drops while any transfer is outstanding.

Counter:
- issue = core_gnt; retire = (wb_ack | wb_err) & (cnt != 0).
- issue & ~retire: cnt+1. retire & ~issue: cnt-1. Both or neither: cnt unchanged.
- ack/err while cnt==0 (spurious, or arriving after reset) is ignored: no rvalid, cnt stays 0.
- wb_ack and wb_err both high: treated as error.

Response path:
- Responses are registered, one cycle after ack/err:
  - core_rvalid <= retire
  - core_err <= wb_err & retire
  - core_rdata <= wb_dat_i when wb_ack & ~wb_err & retire; otherwise 0
- core_rvalid is a single-cycle pulse per retired transfer.
- Responses are returned in issue order; Wishbone slaves must respond in order.
- Minimum latency is core_gnt at cycle N, ack at N+1, core_rvalid at N+2.

Throughput:
- With ack every cycle and MAX_OUTSTANDING>=2, one transfer is granted per cycle back-to-back.

Reset mid-operation:
- Outstanding transfers are dropped and cyc falls.
- No response is ever delivered for them.

Optional Feature:
- Macro CORE2WB_REG_REQ_EN.
- Defined:
  - A one-entry request register is inserted between the core and Wishbone sides.
  - wb_stb, wb_we, wb_adr, wb_sel and wb_dat_o are driven only from registered state, so there is no combinational path from core_* to wb_*.
  - core_gnt = core_req & room_r & (~buf_valid | ~wb_stall), where room_r counts the buffered request as outstanding.
  - The buffer loads on core_gnt and clears when wb_stb & ~wb_stall with no new grant.
  - Minimum latency grows by 1 cycle: gnt at N, stb at N+1, ack at N+2, rvalid at N+3.
  - Back-to-back throughput of 1 per cycle is retained while wb_stall=0.
  - buf_valid resets to 0.
- Undefined: pass-through request path exactly as described above.

Test Plan:
1. Single read: core_req with addr=0x0000_1000, be=0xF; slave acks the next cycle with dat_i=0xDEADBEEF -> gnt at N, rvalid at N+2, rdata=0xDEADBEEF, err=0, cnt returns to 0, cyc drops at N+2.
2. Write with stall: wb_stall=1 for 3 cycles on addr=0x20, wdata=0x12345678, be=0x3 -> gnt low for 3 cycles, then gnt=1; wb_sel=0x3, wb_dat_o=0x12345678 stable throughout; rvalid one cycle after ack.
3. Pipelined limit: MAX_OUTSTANDING=2, req held high, ack withheld -> exactly 2 grants, then gnt=0. One ack -> one rvalid and one further grant. Two acks -> two rvalid in order.
4. Error: wb_err=1 in response to a read -> core_rvalid=1, core_err=1, core_rdata=0. A subsequent read with ack returns err=0.
5. Spurious ack with cnt=0 -> no rvalid. Reset asserted with 2 outstanding -> cyc=0, stb=0 next cycle; a late ack after reset produces no rvalid.
6. Simultaneous issue and retire with ack every cycle over 8 reads -> 8 grants in 8 consecutive cycles, cnt stays at 1, 8 rvalid pulses in issue order. Repeat with CORE2WB_REG_REQ_EN defined -> 1-cycle-later stb and rvalid, same data.
